// File: rtl/pipe_skid_register.sv
// -----------------------------------------------------------------------------
// pipe_skid_register
//
// Chain of STAGES register slices placed between a producer and a consumer in
// the datapath. Each slice is a two-entry skid buffer (main + skid) with a
// valid/ready handshake. The chain gives full throughput (one beat per cycle)
// and a latency of STAGES cycles. in_ready comes only from registers and
// rst/flush, so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   WIDTH        payload width in bits
//   STAGES       number of cascaded slices (1..4), equals the latency in cycles
//   RESET_VALUE  payload loaded into every data register on reset and flush
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   flush      synchronous discard of every buffered beat
//   in_data    upstream payload
//   in_valid   upstream beat present
//   in_ready   block can accept a beat this cycle
//   out_data   downstream payload (main register of the last slice)
//   out_valid  downstream beat present
//   out_ready  downstream accepts a beat this cycle
//   occupancy  number of valid entries held across all slices (0..2*STAGES)
// -----------------------------------------------------------------------------
module pipe_skid_register #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     OCC_W       = $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  // Per-slice state: EMPTY (nothing), HALF (main valid), FULL (main + skid).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } slice_state_e;

  slice_state_e     state_q [STAGES];
  slice_state_e     state_d [STAGES];
  logic [WIDTH-1:0] main_q  [STAGES];
  logic [WIDTH-1:0] main_d  [STAGES];
  logic [WIDTH-1:0] skid_q  [STAGES];
  logic [WIDTH-1:0] skid_d  [STAGES];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Per-slice handshake view: s_in_fire[k] is slice k accepting a beat,
  // s_out_fire[k] is slice k handing its main entry onward.
  logic [STAGES-1:0] s_in_fire;
  logic [STAGES-1:0] s_out_fire;
  logic [WIDTH-1:0]  s_in_data [STAGES];
  logic              in_fire;
  logic              out_fire;

  // Slice input ready is "not FULL", taken straight from the state register.
  assign in_ready  = (state_q[0] != S_FULL) && !rst && !flush;
  assign out_valid = (state_q[STAGES-1] != S_EMPTY);
  assign out_data  = main_q[STAGES-1];
  assign occupancy = occ_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Inter-slice handshakes. Slice k's output fire is slice k+1's input fire;
  // both are derived from registered state only.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    s_in_fire    = '0;
    s_out_fire   = '0;
    s_in_data[0] = in_data;
    s_in_fire[0] = in_fire;
    for (int k = 1; k < STAGES; k++) begin
      s_in_data[k] = main_q[k-1];
      s_in_fire[k] = (state_q[k-1] != S_EMPTY) && (state_q[k] != S_FULL);
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      s_out_fire[k] = (state_q[k] != S_EMPTY) && (state_q[k+1] != S_FULL);
    end
    s_out_fire[STAGES-1] = out_fire;
  end

  // Next-state logic for every slice plus the occupancy counter.
  always_comb begin
    occ_d = occ_q;
    for (int k = 0; k < STAGES; k++) begin
      state_d[k] = state_q[k];
      main_d[k]  = main_q[k];
      skid_d[k]  = skid_q[k];
      case (state_q[k])
        S_EMPTY: begin
          if (s_in_fire[k]) begin
            state_d[k] = S_HALF;
            main_d[k]  = s_in_data[k];
          end
        end
        S_HALF: begin
          if (s_in_fire[k] && s_out_fire[k]) begin
            main_d[k] = s_in_data[k];
          end else if (s_in_fire[k]) begin
            // Downstream stalled: park the new beat in the skid entry.
            state_d[k] = S_FULL;
            skid_d[k]  = s_in_data[k];
          end else if (s_out_fire[k]) begin
            state_d[k] = S_EMPTY;
          end
        end
        S_FULL: begin
          if (s_out_fire[k]) begin
            state_d[k] = S_HALF;
            main_d[k]  = skid_q[k];
          end
        end
        default: state_d[k] = S_EMPTY;
      endcase
    end

    // Internal slice-to-slice transfers do not change the total count.
    if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_fire && out_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end

    // Flush overrides everything; an output fire this cycle has already been
    // seen by the consumer, so dropping its entry here loses nothing.
    if (flush) begin
      occ_d = '0;
      for (int k = 0; k < STAGES; k++) begin
        state_d[k] = S_EMPTY;
        main_d[k]  = RESET_VALUE;
        skid_d[k]  = RESET_VALUE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        state_q[k] <= S_EMPTY;
        // NOTE: the payload registers are reset as well, because an empty
        // block must present RESET_VALUE on out_data.
        main_q[k]  <= RESET_VALUE;
        skid_q[k]  <= RESET_VALUE;
      end
    end else begin
      occ_q <= occ_d;
      for (int k = 0; k < STAGES; k++) begin
        state_q[k] <= state_d[k];
        main_q[k]  <= main_d[k];
        skid_q[k]  <= skid_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_register.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_register
//
// Self-checking bench for pipe_skid_register (STAGES=2, RESET_VALUE=DEAD_BEEF).
// The monitor pushes every accepted input word into an expected queue and pops
// and compares on every output fire; it also checks occupancy against the
// queue depth, in_ready during rst/flush and output stability under stall.
// The stimulus process drives directed vectors and checks cycle-exact latency
// and boundary values.
// -----------------------------------------------------------------------------
module tb_pipe_skid_register;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam logic [31:0] RV     = 32'hDEAD_BEEF;
  localparam int unsigned OCC_W  = $clog2(2 * STAGES + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  bit          mon_en       = 1'b0;
  bit          hold_pending = 1'b0;
  logic [31:0] held_data;
  int          idx;

  always #5 clk = ~clk;

  pipe_skid_register #(
    .WIDTH      (WIDTH),
    .STAGES     (STAGES),
    .RESET_VALUE(RV)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy_vs_inflight", 32'(occupancy), exp_q.size());
      if (hold_pending) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL out_beat: got 0x%08h, expected no beat", out_data);
        end else begin
          check("out_beat", out_data, exp_q.pop_front());
        end
      end
      if (rst || flush) begin
        check("in_ready_blocked", 32'(in_ready), 32'd0);
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
      hold_pending = out_valid && !out_ready && !rst && !flush;
      held_data    = out_data;
    end
  end

  initial begin
    // Reset held for two cycles.
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      next_cycle();
      mon_en = 1'b1;
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_out_data", out_data, RV);
    check("post_rst_occupancy", 32'(occupancy), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Streaming 1..8 with the consumer always ready: latency 2, then 1/cycle.
    for (int i = 0; i <= 10; i++) begin
      drive(i < 8, 32'(i + 1), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (i < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'(i >= 2 && i <= 9));
      if (i >= 2 && i <= 9) check("stream_out_data", out_data, 32'(i - 1));
      if (i >= 2 && i <= 8) check("stream_occupancy", 32'(occupancy), 32'd2);
      next_cycle();
    end

    // Backpressure: A0..A5 against a stalled consumer, released at cycle 8.
    idx = 0;
    for (int c = 0; c < 17; c++) begin
      drive(idx < 6, 32'hA0 + 32'(idx), c >= 8, 1'b0, 1'b0);
      @(negedge clk);
      if (c == 7) begin
        check("bp_full_occupancy", 32'(occupancy), 32'd4);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted_before_release", 32'(idx), 32'd4);
      end
      if (c >= 8 && c <= 13) begin
        check("bp_drain_valid", 32'(out_valid), 32'd1);
        check("bp_drain_data", out_data, 32'hA0 + 32'(c - 8));
      end
      if (c == 16) check("bp_empty_after", 32'(out_valid), 32'd0);
      if (in_valid && in_ready) idx++;
      next_cycle();
    end
    check("bp_all_accepted", 32'(idx), 32'd6);

    // Flush with three beats buffered and a 0x55 beat offered.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'hB0 + 32'(c), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("fl_fill_in_ready", 32'(in_ready), 32'd1);
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_pre_occupancy", 32'(occupancy), 32'd3);
    next_cycle();
    drive(1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd1);
    check("fl_out_data", out_data, 32'hB0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_post_occupancy", 32'(occupancy), 32'd0);
    check("fl_post_out_valid", 32'(out_valid), 32'd0);
    check("fl_post_out_data", out_data, RV);
    check("fl_post_in_ready", 32'(in_ready), 32'd1);
    next_cycle();

    // Reset mid-stream with four beats buffered.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'hC0 + 32'(c), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rm_pre_occupancy", 32'(occupancy), 32'd4);
    check("rm_pre_in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rm_post_occupancy", 32'(occupancy), 32'd0);
    check("rm_post_out_valid", 32'(out_valid), 32'd0);
    check("rm_post_out_data", out_data, RV);
    check("rm_post_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rm_push_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rm_lat1_out_valid", 32'(out_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rm_lat2_out_valid", 32'(out_valid), 32'd1);
    check("rm_lat2_out_data", out_data, 32'h77);
    next_cycle();
    @(negedge clk);
    check("rm_after_out_valid", 32'(out_valid), 32'd0);
    next_cycle();

    // Random valid/ready toggling; the monitor checks order and occupancy.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) next_cycle();
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
